// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: two-entry (main + skid) pipeline register with valid/ready
// handshaking. In_Ready is decoded from the registered occupancy only, so
// there is no combinational path from Out_Ready back to In_Ready.
// Optional feature: define PIPE_STAGE_STALL_CNT_EN to add the Stall_Cnt
// output, a saturating count of cycles where the output is stalled.
module pipe_stage_reg #(
    parameter int DATA_W = 68,
    parameter int CTRL_W = 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              FLUSH,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [CTRL_W-1:0] In_Ctrl,
    input  logic [DATA_W-1:0] In_Data,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [CTRL_W-1:0] Out_Ctrl,
    output logic [DATA_W-1:0] Out_Data
`ifdef PIPE_STAGE_STALL_CNT_EN
    ,
    output logic [15:0]       Stall_Cnt
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_main_data;
    logic [CTRL_W-1:0]   r_main_ctrl;
    logic [DATA_W-1:0]   r_skid_data;
    logic [CTRL_W-1:0]   r_skid_ctrl;
    logic                w_push;
    logic                w_pop;
    logic                w_main_ld_in;
    logic                w_main_ld_skid;
    logic                w_skid_ld;

    assign In_Ready  = (r_state != ST_FULL);
    assign Out_Valid = (r_state != ST_EMPTY);
    assign w_push    = In_Valid & In_Ready;
    assign w_pop     = Out_Valid & Out_Ready;

    // Bubbles carry all-zero control so they never write back or touch memory;
    // the payload simply keeps its last value.
    assign Out_Ctrl  = Out_Valid ? r_main_ctrl : {CTRL_W{1'b0}};
    assign Out_Data  = r_main_data;

    // Occupancy state register; reset has priority over everything.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next occupancy and entry load enables; flush overrides push/pop.
    always_comb begin
        w_state_nxt    = r_state;
        w_main_ld_in   = 1'b0;
        w_main_ld_skid = 1'b0;
        w_skid_ld      = 1'b0;
        if (FLUSH) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_push) begin
                        w_state_nxt  = ST_ONE;
                        w_main_ld_in = 1'b1;
                    end else begin
                        w_state_nxt  = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (w_push && w_pop) begin
                        w_state_nxt  = ST_ONE;
                        w_main_ld_in = 1'b1;
                    end else if (w_push) begin
                        w_state_nxt  = ST_FULL;
                        w_skid_ld    = 1'b1;
                    end else if (w_pop) begin
                        w_state_nxt  = ST_EMPTY;
                    end else begin
                        w_state_nxt  = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (w_pop) begin
                        w_state_nxt    = ST_ONE;
                        w_main_ld_skid = 1'b1;
                    end else begin
                        w_state_nxt    = ST_FULL;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    // Main entry: takes the input or drains the skid entry, otherwise holds.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_main_data <= {DATA_W{1'b0}};
            r_main_ctrl <= {CTRL_W{1'b0}};
        end else if (w_main_ld_in) begin
            r_main_data <= In_Data;
            r_main_ctrl <= In_Ctrl;
        end else if (w_main_ld_skid) begin
            r_main_data <= r_skid_data;
            r_main_ctrl <= r_skid_ctrl;
        end else begin
            r_main_data <= r_main_data;
            r_main_ctrl <= r_main_ctrl;
        end
    end

    // Skid entry: captures the beat accepted while the main entry is blocked.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_skid_data <= {DATA_W{1'b0}};
            r_skid_ctrl <= {CTRL_W{1'b0}};
        end else if (w_skid_ld) begin
            r_skid_data <= In_Data;
            r_skid_ctrl <= In_Ctrl;
        end else begin
            r_skid_data <= r_skid_data;
            r_skid_ctrl <= r_skid_ctrl;
        end
    end

`ifdef PIPE_STAGE_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    assign Stall_Cnt = r_stall_cnt;

    // Saturating stall counter; cleared by reset only, flush leaves it alone.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stall_cnt <= 16'h0000;
        end else if (Out_Valid && !Out_Ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'h0001;
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end
`endif

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 68, SHALL set the payload width (ALU result + store value + dest).
REQ-002 Parameter CTRL_W, default 3, SHALL set the control-bit width (WB_EN, MEM_R_EN, MEM_W_EN).
REQ-003 CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 RST  input  1  SHALL be the synchronous, active-high reset.
REQ-005 FLUSH  input  1  SHALL be a synchronous stage-clear request.
REQ-006 In_Valid  input  1  SHALL mark the upstream beat as valid.
REQ-007 In_Ready  output  1  SHALL mark that the stage can accept a beat this cycle.
REQ-008 In_Ctrl  input  CTRL_W  SHALL carry the upstream control bits.
REQ-009 In_Data  input  DATA_W  SHALL carry the upstream payload.
REQ-010 Out_Valid  output  1  SHALL mark the downstream beat as valid.
REQ-011 Out_Ready  input  1  SHALL mark that the downstream stage accepts the beat.
REQ-012 Out_Ctrl  output  CTRL_W  SHALL carry the control bits of the head entry.
REQ-013 Out_Data  output  DATA_W  SHALL carry the payload of the head entry.
REQ-014 Stall_Cnt  output  16  SHALL count output stall cycles; present only under the macro (REQ-030).

Function
REQ-015 Storage SHALL be two entries: main (drives outputs) and skid; occupancy states EMPTY, ONE, FULL.
REQ-016 Push SHALL occur when In_Valid & In_Ready; pop SHALL occur when Out_Valid & Out_Ready.
REQ-017 In_Ready SHALL equal (state != FULL), decoded from registered state only, with no path from Out_Ready.
REQ-018 Out_Valid SHALL equal (state != EMPTY).
REQ-019 EMPTY: push -> ONE, main loads input; otherwise stay.
REQ-020 ONE: push & pop -> ONE, main loads input; push & !pop -> FULL, skid loads input; pop only -> EMPTY; neither -> hold.
REQ-021 FULL: pop -> ONE, main loads skid; otherwise hold; no push is possible.
REQ-022 Latency SHALL be 1 cycle from push into EMPTY to Out_Valid; beats SHALL leave in arrival order, none dropped or duplicated.
REQ-023 With Out_Ready held 1, throughput SHALL be one beat per cycle and occupancy SHALL never exceed ONE.
REQ-024 Out_Ctrl SHALL be forced to all zeros whenever Out_Valid is 0 (bubbles never write back or access memory).
REQ-025 Out_Data SHALL hold its last value when Out_Valid is 0.
REQ-026 FLUSH SHALL force EMPTY at the next edge, discarding both entries and any push in the same cycle.
REQ-027 Priority SHALL be RST > FLUSH > push/pop.

Reset
REQ-028 At an edge with RST high: state EMPTY, main and skid cleared to zero, Out_Valid 0, Out_Ctrl 0, Out_Data 0, In_Ready 1, Stall_Cnt 0.
REQ-029 A push or pop presented in a reset cycle SHALL be ignored; RST asserted mid-transfer SHALL discard all stored beats.

Configuration
REQ-030 With macro PIPE_STAGE_STALL_CNT_EN defined, Stall_Cnt SHALL exist and increment by 1 each cycle with Out_Valid & !Out_Ready, saturate at 16'hFFFF, clear only on RST, and be unaffected by FLUSH.
REQ-031 Without PIPE_STAGE_STALL_CNT_EN, port Stall_Cnt and its counter SHALL be absent; all other behaviour identical.

Verification
REQ-032 Reset: RST=1 for 2 cycles with In_Valid=1 -> Out_Valid=0, Out_Ctrl=0, Out_Data=0, In_Ready=1.
REQ-033 Streaming: Out_Ready=1, push 0x1,0x2,0x3 on consecutive cycles -> Out_Data 0x1,0x2,0x3 on the following consecutive cycles, In_Ready stays 1.
REQ-034 Backpressure: Out_Ready=0, push 0xA then 0xB -> In_Ready=0 after second push, 0xC held off; raise Out_Ready -> 0xA, 0xB, 0xC delivered in order.
REQ-035 Flush: FULL with 0xA,0xB plus In_Valid=1 of 0xC and FLUSH=1 -> next cycle Out_Valid=0, Out_Ctrl=0, In_Ready=1; 0xC never appears.
REQ-036 Bubble control: push In_Ctrl=3'b111 once, Out_Ready=1 -> Out_Ctrl=3'b111 for one cycle, then 3'b000 with Out_Valid=0.
REQ-037 Stall counter (macro on): hold Out_Valid=1, Out_Ready=0 for 70000 cycles -> Stall_Cnt=16'hFFFF; FLUSH -> stays 16'hFFFF; RST -> 0.
